// File: rtl/rv_ex_stage.sv
// rv32i execute stage: operand forwarding, ALU, branch/jump resolution and EX/MEM registers.
// Optional branch performance counters are enabled by defining RV_EX_PERF_CNT_EN.
module rv_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_ex_clk,
  input  logic            i_ex_rst,
  input  logic            i_ex_valid,
  input  logic            i_ex_stall,
  input  logic            i_ex_flush,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_ex_rs1_data,
  input  logic [XLEN-1:0] i_ex_rs2_data,
  input  logic [XLEN-1:0] i_ex_ext_imm,
  input  logic [3:0]      i_ex_alu_ctrl,
  input  logic            i_ex_alu_a_sel,
  input  logic            i_ex_alu_b_sel,
  input  logic [1:0]      i_ex_fwd_a_sel,
  input  logic [1:0]      i_ex_fwd_b_sel,
  input  logic [XLEN-1:0] i_ex_mem_fwd,
  input  logic [XLEN-1:0] i_ex_wb_fwd,
  input  logic            i_ex_is_branch,
  input  logic            i_ex_is_jal,
  input  logic            i_ex_is_jalr,
  input  logic [2:0]      i_ex_br_funct3,
  input  logic            i_ex_is_load,
  input  logic            i_ex_dmem_we,
  input  logic            i_ex_rf_we,
  input  logic [2:0]      i_ex_dmem_bytectrl,
  input  logic [4:0]      i_ex_rf_wa,
  input  logic [1:0]      i_ex_rf_wd_pre_sel,
  output logic            o_ex_pc_redirect,
  output logic [XLEN-1:0] o_ex_pc_target,
  output logic            o_ex_mem_valid,
  output logic            o_ex_mem_is_load,
  output logic            o_ex_mem_dmem_we,
  output logic            o_ex_mem_rf_we,
  output logic [XLEN-1:0] o_ex_mem_alu_res,
  output logic [XLEN-1:0] o_ex_mem_ext_imm,
  output logic [XLEN-1:0] o_ex_mem_pc_plus_4,
  output logic [XLEN-1:0] o_ex_mem_dmem_wd,
  output logic [2:0]      o_ex_mem_dmem_bytectrl,
  output logic [4:0]      o_ex_mem_rf_wa,
  output logic [1:0]      o_ex_mem_rf_wd_pre_sel
`ifdef RV_EX_PERF_CNT_EN
  ,
  output logic [31:0]     o_ex_br_total_cnt,
  output logic [31:0]     o_ex_br_taken_cnt
`endif
);

  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [XLEN-1:0]    alu_a;
  logic [XLEN-1:0]    alu_b;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    jalr_sum;
  logic [SHAMT_W-1:0] shamt;
  logic               lt_s;
  logic               lt_u;
  logic               eq;
  logic               cond_true;
  logic               advance;

  // Forwarding muxes; codes 0 and 3 both select register-file data
  always_comb begin
    op_a = i_ex_rs1_data;
    op_b = i_ex_rs2_data;
    case (i_ex_fwd_a_sel)
      2'd1:    op_a = i_ex_mem_fwd;
      2'd2:    op_a = i_ex_wb_fwd;
      default: op_a = i_ex_rs1_data;
    endcase
    case (i_ex_fwd_b_sel)
      2'd1:    op_b = i_ex_mem_fwd;
      2'd2:    op_b = i_ex_wb_fwd;
      default: op_b = i_ex_rs2_data;
    endcase
  end

  assign alu_a = i_ex_alu_a_sel ? i_ex_pc : op_a;
  assign alu_b = i_ex_alu_b_sel ? i_ex_ext_imm : op_b;
  assign shamt = alu_b[SHAMT_W-1:0];

  // ALU; unused opcodes fall back to ADD
  always_comb begin
    alu_res = alu_a + alu_b;
    case (i_ex_alu_ctrl)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> shamt);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_PASS: alu_res = alu_b;
      default:  alu_res = alu_a + alu_b;
    endcase
  end

  // Branch comparison always uses forwarded register operands, never the ALU muxes
  assign eq   = (op_a == op_b);
  assign lt_s = ($signed(op_a) < $signed(op_b));
  assign lt_u = (op_a < op_b);

  always_comb begin
    cond_true = 1'b0;
    case (i_ex_br_funct3)
      BR_EQ:   cond_true = eq;
      BR_NE:   cond_true = ~eq;
      BR_LT:   cond_true = lt_s;
      BR_GE:   cond_true = ~lt_s;
      BR_LTU:  cond_true = lt_u;
      BR_GEU:  cond_true = ~lt_u;
      default: cond_true = 1'b0;
    endcase
  end

  assign jalr_sum       = op_a + i_ex_ext_imm;
  assign o_ex_pc_target = i_ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_ex_pc + i_ex_ext_imm);

  assign advance          = i_ex_valid & ~i_ex_stall & ~i_ex_flush;
  assign o_ex_pc_redirect = advance & (i_ex_is_jal | i_ex_is_jalr | (i_ex_is_branch & cond_true));

  // EX/MEM registers: reset > flush > stall > load; flush keeps data fields
  always_ff @(posedge i_ex_clk) begin
    if (i_ex_rst) begin
      o_ex_mem_valid         <= 1'b0;
      o_ex_mem_is_load       <= 1'b0;
      o_ex_mem_dmem_we       <= 1'b0;
      o_ex_mem_rf_we         <= 1'b0;
      o_ex_mem_alu_res       <= '0;
      o_ex_mem_ext_imm       <= '0;
      o_ex_mem_pc_plus_4     <= '0;
      o_ex_mem_dmem_wd       <= '0;
      o_ex_mem_dmem_bytectrl <= '0;
      o_ex_mem_rf_wa         <= '0;
      o_ex_mem_rf_wd_pre_sel <= '0;
    end else if (i_ex_flush) begin
      o_ex_mem_valid   <= 1'b0;
      o_ex_mem_is_load <= 1'b0;
      o_ex_mem_dmem_we <= 1'b0;
      o_ex_mem_rf_we   <= 1'b0;
    end else if (!i_ex_stall) begin
      o_ex_mem_valid         <= i_ex_valid;
      o_ex_mem_is_load       <= i_ex_is_load & i_ex_valid;
      o_ex_mem_dmem_we       <= i_ex_dmem_we & i_ex_valid;
      o_ex_mem_rf_we         <= i_ex_rf_we & i_ex_valid;
      o_ex_mem_alu_res       <= alu_res;
      o_ex_mem_ext_imm       <= i_ex_ext_imm;
      o_ex_mem_pc_plus_4     <= i_ex_pc + XLEN'(4);
      o_ex_mem_dmem_wd       <= op_b;
      o_ex_mem_dmem_bytectrl <= i_ex_dmem_bytectrl;
      o_ex_mem_rf_wa         <= i_ex_rf_wa;
      o_ex_mem_rf_wd_pre_sel <= i_ex_rf_wd_pre_sel;
    end
  end

`ifdef RV_EX_PERF_CNT_EN
  // Branch statistics; counts wrap naturally at 2^32
  always_ff @(posedge i_ex_clk) begin
    if (i_ex_rst) begin
      o_ex_br_total_cnt <= '0;
      o_ex_br_taken_cnt <= '0;
    end else if (advance && i_ex_is_branch) begin
      o_ex_br_total_cnt <= o_ex_br_total_cnt + 32'd1;
      if (cond_true) o_ex_br_taken_cnt <= o_ex_br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv_ex_stage.sv
// Directed self-checking bench for rv_ex_stage; counter checks run when RV_EX_PERF_CNT_EN is defined.
module tb_rv_ex_stage;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, valid, stall, flush;
  logic [XLEN-1:0] pc, rs1, rs2, imm, mem_fwd, wb_fwd;
  logic [3:0]      alu_ctrl;
  logic            a_sel, b_sel;
  logic [1:0]      fwd_a, fwd_b;
  logic            is_branch, is_jal, is_jalr;
  logic [2:0]      funct3;
  logic            is_load, dmem_we, rf_we;
  logic [2:0]      bytectrl;
  logic [4:0]      rf_wa;
  logic [1:0]      wd_sel;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            m_valid, m_is_load, m_dmem_we, m_rf_we;
  logic [XLEN-1:0] m_alu_res, m_ext_imm, m_pc4, m_wd;
  logic [2:0]      m_bytectrl;
  logic [4:0]      m_rf_wa;
  logic [1:0]      m_wd_sel;
`ifdef RV_EX_PERF_CNT_EN
  logic [31:0]     br_total, br_taken;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_ex_stage #(.XLEN(XLEN)) dut (
    .i_ex_clk(clk), .i_ex_rst(rst), .i_ex_valid(valid), .i_ex_stall(stall), .i_ex_flush(flush),
    .i_ex_pc(pc), .i_ex_rs1_data(rs1), .i_ex_rs2_data(rs2), .i_ex_ext_imm(imm),
    .i_ex_alu_ctrl(alu_ctrl), .i_ex_alu_a_sel(a_sel), .i_ex_alu_b_sel(b_sel),
    .i_ex_fwd_a_sel(fwd_a), .i_ex_fwd_b_sel(fwd_b), .i_ex_mem_fwd(mem_fwd), .i_ex_wb_fwd(wb_fwd),
    .i_ex_is_branch(is_branch), .i_ex_is_jal(is_jal), .i_ex_is_jalr(is_jalr),
    .i_ex_br_funct3(funct3), .i_ex_is_load(is_load), .i_ex_dmem_we(dmem_we), .i_ex_rf_we(rf_we),
    .i_ex_dmem_bytectrl(bytectrl), .i_ex_rf_wa(rf_wa), .i_ex_rf_wd_pre_sel(wd_sel),
    .o_ex_pc_redirect(redirect), .o_ex_pc_target(target),
    .o_ex_mem_valid(m_valid), .o_ex_mem_is_load(m_is_load), .o_ex_mem_dmem_we(m_dmem_we),
    .o_ex_mem_rf_we(m_rf_we), .o_ex_mem_alu_res(m_alu_res), .o_ex_mem_ext_imm(m_ext_imm),
    .o_ex_mem_pc_plus_4(m_pc4), .o_ex_mem_dmem_wd(m_wd), .o_ex_mem_dmem_bytectrl(m_bytectrl),
    .o_ex_mem_rf_wa(m_rf_wa), .o_ex_mem_rf_wd_pre_sel(m_wd_sel)
`ifdef RV_EX_PERF_CNT_EN
    , .o_ex_br_total_cnt(br_total), .o_ex_br_taken_cnt(br_taken)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change and registered outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; stall = 0; flush = 0; pc = '0; rs1 = '0; rs2 = '0; imm = '0;
    mem_fwd = '0; wb_fwd = '0; alu_ctrl = '0; a_sel = 0; b_sel = 0; fwd_a = '0; fwd_b = '0;
    is_branch = 0; is_jal = 0; is_jalr = 0; funct3 = '0; is_load = 0; dmem_we = 0;
    rf_we = 0; bytectrl = '0; rf_wa = '0; wd_sel = '0;
  endtask

  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic bs, input logic [31:0] im);
    idle();
    valid = 1; rf_we = 1; rf_wa = 5'd1; alu_ctrl = op; rs1 = a; rs2 = b; b_sel = bs; imm = im;
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_rf_we", 32'(m_rf_we), 32'd0);
    chk("rst_alu_res", m_alu_res, 32'd0);
    chk("rst_pc4", m_pc4, 32'd0);
    chk("rst_rf_wa", 32'(m_rf_wa), 32'd0);
    rst = 0;

    // ADD 5 + 7
    idle();
    valid = 1; rs1 = 32'd5; rs2 = 32'd7; rf_we = 1; rf_wa = 5'd3; pc = 32'h100;
    tick();
    chk("add_res", m_alu_res, 32'd12);
    chk("add_rf_we", 32'(m_rf_we), 32'd1);
    chk("add_rf_wa", 32'(m_rf_wa), 32'd3);
    chk("add_pc4", m_pc4, 32'h104);
    chk("add_valid", 32'(m_valid), 32'd1);
    chk("add_wd", m_wd, 32'd7);

    // SUB with MEM/WB forwarding
    idle();
    valid = 1; fwd_a = 2'd1; mem_fwd = 32'h100; fwd_b = 2'd2; wb_fwd = 32'h20;
    rs1 = 32'hDEAD; rs2 = 32'hBEEF; alu_ctrl = 4'd1;
    tick();
    chk("fwd_sub", m_alu_res, 32'hE0);
    chk("fwd_wd", m_wd, 32'h20);

    alu_op(4'd3, 32'hFFFFFFFF, 32'd1, 0, 0);
    chk("slt", m_alu_res, 32'd1);
    alu_op(4'd4, 32'hFFFFFFFF, 32'd1, 0, 0);
    chk("sltu", m_alu_res, 32'd0);
    alu_op(4'd7, 32'h80000000, 32'd0, 1, 32'h24);
    chk("sra_shamt5", m_alu_res, 32'hF8000000);
    alu_op(4'd6, 32'h80000000, 32'd4, 0, 0);
    chk("srl", m_alu_res, 32'h08000000);
    alu_op(4'd2, 32'h1, 32'd31, 0, 0);
    chk("sll", m_alu_res, 32'h80000000);
    alu_op(4'd5, 32'hF0F0, 32'hFF00, 0, 0);
    chk("xor", m_alu_res, 32'h0FF0);
    alu_op(4'd8, 32'hF0F0, 32'hFF00, 0, 0);
    chk("or", m_alu_res, 32'hFFF0);
    alu_op(4'd9, 32'hF0F0, 32'hFF00, 0, 0);
    chk("and", m_alu_res, 32'hF000);
    alu_op(4'd10, 32'h1234, 32'd0, 1, 32'h55AA);
    chk("pass_b", m_alu_res, 32'h55AA);
    alu_op(4'd13, 32'hFFFFFFFF, 32'd2, 0, 0);
    chk("op13_add_wrap", m_alu_res, 32'd1);

    // AUIPC-style: pc + imm
    idle();
    valid = 1; a_sel = 1; b_sel = 1; pc = 32'h400; imm = 32'h1000; rs1 = 32'h7;
    tick();
    chk("pc_plus_imm", m_alu_res, 32'h1400);

    // Branches: opA = -1, opB = 1, pc = 0x40, imm = -8
    idle();
    valid = 1; is_branch = 1; funct3 = 3'd4; rs1 = 32'hFFFFFFFF; rs2 = 32'd1;
    pc = 32'h40; imm = 32'hFFFFFFF8;
    #1;
    chk("blt_redirect", 32'(redirect), 32'd1);
    chk("blt_target", target, 32'h38);
    funct3 = 3'd7; #1;
    chk("bgeu_redirect", 32'(redirect), 32'd1);
    chk("bgeu_target", target, 32'h38);
    funct3 = 3'd6; #1;
    chk("bltu_redirect", 32'(redirect), 32'd0);
    funct3 = 3'd5; #1;
    chk("bge_redirect", 32'(redirect), 32'd0);
    funct3 = 3'd1; #1;
    chk("bne_redirect", 32'(redirect), 32'd1);
    funct3 = 3'd0; #1;
    chk("beq_redirect", 32'(redirect), 32'd0);
    rs2 = 32'hFFFFFFFF; #1;
    chk("beq_eq_redirect", 32'(redirect), 32'd1);
    funct3 = 3'd2; #1;
    chk("f3_2_never", 32'(redirect), 32'd0);
    funct3 = 3'd4; rs2 = 32'd1; stall = 1; #1;
    chk("blt_stall", 32'(redirect), 32'd0);
    stall = 0; flush = 1; #1;
    chk("blt_flush", 32'(redirect), 32'd0);
    flush = 0; valid = 0; #1;
    chk("blt_bubble", 32'(redirect), 32'd0);

    // JALR: (0x1003 + 2) & ~1
    idle();
    valid = 1; is_jalr = 1; rs1 = 32'h1003; imm = 32'd2; pc = 32'h200;
    rf_we = 1; rf_wa = 5'd1; wd_sel = 2'd2;
    #1;
    chk("jalr_redirect", 32'(redirect), 32'd1);
    chk("jalr_target", target, 32'h1004);
    tick();
    chk("jalr_pc4", m_pc4, 32'h204);
    chk("jalr_wd_sel", 32'(m_wd_sel), 32'd2);
    chk("jalr_rf_we", 32'(m_rf_we), 32'd1);

    idle();
    valid = 1; is_jal = 1; pc = 32'h300; imm = 32'h10;
    #1;
    chk("jal_redirect", 32'(redirect), 32'd1);
    chk("jal_target", target, 32'h310);

    // Load captured, then held across a 2-cycle stall
    idle();
    valid = 1; is_load = 1; rf_we = 1; rs1 = 32'h1000; b_sel = 1; imm = 32'd4;
    bytectrl = 3'b010; rf_wa = 5'd5; pc = 32'h500;
    tick();
    chk("ld_res", m_alu_res, 32'h1004);
    chk("ld_is_load", 32'(m_is_load), 32'd1);
    chk("ld_bytectrl", 32'(m_bytectrl), 32'd2);
    chk("ld_ext_imm", m_ext_imm, 32'd4);
    rs1 = 32'h2000; rf_wa = 5'd9; pc = 32'h600; stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_res", m_alu_res, 32'h1004);
      chk("stall_rf_wa", 32'(m_rf_wa), 32'd5);
      chk("stall_is_load", 32'(m_is_load), 32'd1);
      chk("stall_pc4", m_pc4, 32'h504);
    end
    flush = 1; dmem_we = 1;
    tick();
    chk("flush_valid", 32'(m_valid), 32'd0);
    chk("flush_is_load", 32'(m_is_load), 32'd0);
    chk("flush_rf_we", 32'(m_rf_we), 32'd0);
    chk("flush_dmem_we", 32'(m_dmem_we), 32'd0);
    chk("flush_keeps_data", m_alu_res, 32'h1004);
    stall = 0; flush = 0; valid = 0;
    tick();
    chk("bubble_rf_we", 32'(m_rf_we), 32'd0);
    chk("bubble_dmem_we", 32'(m_dmem_we), 32'd0);
    chk("bubble_valid", 32'(m_valid), 32'd0);
    chk("bubble_res", m_alu_res, 32'h2004);

    // Reset mid-operation clears the in-flight slot
    valid = 1; rf_wa = 5'd0;
    tick();
    chk("x0_passthru", 32'(m_rf_wa), 32'd0);
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1;
    tick();
    chk("midrst_valid", 32'(m_valid), 32'd0);
    chk("midrst_res", m_alu_res, 32'd0);
    rst = 0;

`ifdef RV_EX_PERF_CNT_EN
    idle();
    tick();
    chk("cnt_total_rst", br_total, 32'd0);
    chk("cnt_taken_rst", br_taken, 32'd0);
    valid = 1; is_branch = 1; rs1 = 32'd3; rs2 = 32'd3;
    funct3 = 3'd0; tick();
    funct3 = 3'd1; tick();
    stall = 1; funct3 = 3'd0; tick();
    stall = 0; funct3 = 3'd5; tick();
    valid = 0;
    tick();
    chk("cnt_total", br_total, 32'd3);
    chk("cnt_taken", br_taken, 32'd2);
    rst = 1;
    tick();
    chk("cnt_total_midrst", br_total, 32'd0);
    chk("cnt_taken_midrst", br_taken, 32'd0);
    rst = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
